rob: RTL and testbench

//  Reorder buffer: allocates in-order tags to decoded instructions and receives EX results.

---
 rtl/rob_if.sv | 46 ++++
 rtl/rob.sv | 127 ++++++++++++
 tb/tb_rob.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Decoder/EX/commit signal bundle for the reorder buffer.
// The rob module uses the slave side. Decoder, EX and regfile use the master side.
interface rob_if #(
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5
);
    logic                  rdy;
    logic                  if_issue_rob;
    logic [REG_WIDTH-1:0]  dest_reg;
    logic                  is_branch;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic                  if_idle;
    logic [TAG_WIDTH-1:0]  free_tag;
    logic [TAG_WIDTH-1:0]  query_tag;
    logic                  query_ready;
    logic [DATA_WIDTH-1:0] query_data;
    logic [TAG_WIDTH-1:0]  tag_from_ex;
    logic [DATA_WIDTH-1:0] data_from_ex;
    logic                  taken_from_ex;
    logic [ADDR_WIDTH-1:0] target_from_ex;
    logic [TAG_WIDTH-1:0]  tag_renew;
    logic [DATA_WIDTH-1:0] data_renew;
    logic                  commit_en;
    logic [REG_WIDTH-1:0]  commit_reg;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [TAG_WIDTH-1:0]  commit_tag;
    logic                  clear;
    logic [ADDR_WIDTH-1:0] pc_redirect;

    modport slave (
        input  rdy, if_issue_rob, dest_reg, is_branch, pred_taken, pc_in, query_tag,
               tag_from_ex, data_from_ex, taken_from_ex, target_from_ex,
        output if_idle, free_tag, query_ready, query_data, tag_renew, data_renew,
               commit_en, commit_reg, commit_data, commit_tag, clear, pc_redirect
    );

    modport master (
        output rdy, if_issue_rob, dest_reg, is_branch, pred_taken, pc_in, query_tag,
               tag_from_ex, data_from_ex, taken_from_ex, target_from_ex,
        input  if_idle, free_tag, query_ready, query_data, tag_renew, data_renew,
               commit_en, commit_reg, commit_data, commit_tag, clear, pc_redirect
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order tag allocation, EX result broadcast, in-order commit.
// A mispredicted branch at commit flushes the whole buffer and redirects fetch.
module rob #(
    parameter int unsigned ROB_SIZE   = 16,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5
) (
    input logic clk,
    input logic rst,
    rob_if.slave bus
);
    localparam logic [TAG_WIDTH-1:0] FIRST = TAG_WIDTH'(1);
    localparam logic [TAG_WIDTH-1:0] LAST  = TAG_WIDTH'(ROB_SIZE - 1);

    logic [ROB_SIZE-1:0]   busy;
    logic [ROB_SIZE-1:0]   ready;
    logic [REG_WIDTH-1:0]  dest_q   [ROB_SIZE];
    logic                  br_q     [ROB_SIZE];
    logic                  pred_q   [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] pc_q     [ROB_SIZE];
    logic [DATA_WIDTH-1:0] value_q  [ROB_SIZE];
    logic                  taken_q  [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] target_q [ROB_SIZE];

    logic [TAG_WIDTH-1:0] head, tail, count;
    logic idle, do_alloc, do_wb, do_commit, mispredict;

    function automatic logic [TAG_WIDTH-1:0] next_idx(input logic [TAG_WIDTH-1:0] i);
        return (i == LAST) ? FIRST : i + FIRST;
    endfunction

    assign idle       = (count != LAST);
    assign do_commit  = bus.rdy && busy[head] && ready[head];
    assign mispredict = do_commit && br_q[head] && (taken_q[head] != pred_q[head]);
    assign do_alloc   = bus.if_issue_rob && idle && bus.rdy && !mispredict;
    assign do_wb      = bus.rdy && (bus.tag_from_ex != '0) && busy[bus.tag_from_ex] && !mispredict;

    assign bus.if_idle  = idle;
    assign bus.free_tag = tail;

    // EX result being written back this cycle wins over the stored value.
    always_comb begin
        bus.query_ready = 1'b0;
        bus.query_data  = value_q[bus.query_tag];
        if (bus.query_tag != '0 && bus.query_tag == bus.tag_from_ex) begin
            bus.query_ready = 1'b1;
            bus.query_data  = bus.data_from_ex;
        end else if (busy[bus.query_tag] && ready[bus.query_tag]) begin
            bus.query_ready = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy            <= '0;
            ready           <= '0;
            head            <= FIRST;
            tail            <= FIRST;
            count           <= '0;
            bus.tag_renew   <= '0;
            bus.data_renew  <= '0;
            bus.commit_en   <= 1'b0;
            bus.commit_reg  <= '0;
            bus.commit_data <= '0;
            bus.commit_tag  <= '0;
            bus.clear       <= 1'b0;
            bus.pc_redirect <= '0;
        end else begin
            bus.commit_en <= 1'b0;
            bus.clear     <= 1'b0;
            bus.tag_renew <= '0;
            if (do_commit) begin
                bus.commit_en   <= (dest_q[head] != '0);
                bus.commit_reg  <= dest_q[head];
                bus.commit_data <= value_q[head];
                bus.commit_tag  <= head;
            end
            if (mispredict) begin
                bus.clear       <= 1'b1;
                bus.pc_redirect <= taken_q[head] ? target_q[head]
                                                 : pc_q[head] + ADDR_WIDTH'(4);
                busy            <= '0;
                ready           <= '0;
                head            <= FIRST;
                tail            <= FIRST;
                count           <= '0;
            end else begin
                if (do_wb) begin
                    ready[bus.tag_from_ex] <= 1'b1;
                    bus.tag_renew          <= bus.tag_from_ex;
                    bus.data_renew         <= bus.data_from_ex;
                end
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= next_idx(head);
                end
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= next_idx(tail);
                end
                case ({do_alloc, do_commit})
                    2'b10:   count <= count + FIRST;
                    2'b01:   count <= count - FIRST;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            dest_q[tail] <= bus.dest_reg;
            br_q[tail]   <= bus.is_branch;
            pred_q[tail] <= bus.pred_taken;
            pc_q[tail]   <= bus.pc_in;
        end
        if (do_wb) begin
            value_q[bus.tag_from_ex]  <= bus.data_from_ex;
            taken_q[bus.tag_from_ex]  <= bus.taken_from_ex;
            target_q[bus.tag_from_ex] <= bus.target_from_ex;
        end
    end
endmodule

// File: tb/tb_rob.sv
// Bench for rob: queue-based program-order model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob;
    localparam int unsigned RS = 16;
    localparam int unsigned TW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    rob_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

    rob #(.ROB_SIZE(RS), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [TW-1:0] tag;
        logic [RW-1:0] dest;
        logic          br;
        logic          pred;
        logic [AW-1:0] pc;
        logic          done;
        logic [DW-1:0] val;
        logic          tk;
        logic [AW-1:0] tgt;
    } ent_t;

    // Program-order model: the queue front is the oldest instruction.
    ent_t q[$];
    logic [TW-1:0] m_tail;
    logic [TW-1:0] e_tag_renew, e_commit_tag;
    logic [DW-1:0] e_data_renew, e_commit_data;
    logic [RW-1:0] e_commit_reg;
    logic [AW-1:0] e_pc_redirect;
    logic          e_commit_en, e_clear;

    always @(posedge clk or posedge rst) begin
        ent_t h, n;
        bit com, misp;
        int unsigned n0;
        if (rst) begin
            q.delete();
            m_tail = 1;
            e_tag_renew = 0; e_data_renew = 0; e_commit_en = 0; e_commit_reg = 0;
            e_commit_data = 0; e_commit_tag = 0; e_clear = 0; e_pc_redirect = 0;
        end else if (!bus.rdy) begin
            e_commit_en = 0; e_clear = 0; e_tag_renew = 0;
        end else begin
            n0 = q.size();
            com = (n0 > 0) && q[0].done;
            if (com) h = q[0];
            misp = com && h.br && (h.tk != h.pred);
            e_commit_en = com && (h.dest != 0);
            if (com) begin
                e_commit_reg = h.dest; e_commit_data = h.val; e_commit_tag = h.tag;
            end
            e_clear = misp;
            if (misp) e_pc_redirect = h.tk ? h.tgt : h.pc + 32'd4;
            e_tag_renew = 0;
            if (!misp && bus.tag_from_ex != 0)
                foreach (q[i])
                    if (q[i].tag == bus.tag_from_ex) begin
                        q[i].done = 1; q[i].val = bus.data_from_ex;
                        q[i].tk = bus.taken_from_ex; q[i].tgt = bus.target_from_ex;
                        e_tag_renew = bus.tag_from_ex; e_data_renew = bus.data_from_ex;
                    end
            if (misp) begin
                q.delete();
                m_tail = 1;
            end else begin
                if (com) void'(q.pop_front());
                if (bus.if_issue_rob && n0 < RS - 1) begin
                    n.tag = m_tail; n.dest = bus.dest_reg; n.br = bus.is_branch;
                    n.pred = bus.pred_taken; n.pc = bus.pc_in; n.done = 0;
                    n.val = 0; n.tk = 0; n.tgt = 0;
                    q.push_back(n);
                    m_tail = (m_tail == 4'(RS - 1)) ? 4'd1 : m_tail + 4'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit qr;
        logic [DW-1:0] qd;
        if (!rst) begin
            chk("if_idle", 64'(bus.if_idle), 64'(q.size() != RS - 1));
            chk("free_tag", 64'(bus.free_tag), 64'(m_tail));
            chk("tag_renew", 64'(bus.tag_renew), 64'(e_tag_renew));
            if (e_tag_renew != 0) chk("data_renew", 64'(bus.data_renew), 64'(e_data_renew));
            chk("commit_en", 64'(bus.commit_en), 64'(e_commit_en));
            if (e_commit_en) begin
                chk("commit_reg", 64'(bus.commit_reg), 64'(e_commit_reg));
                chk("commit_data", 64'(bus.commit_data), 64'(e_commit_data));
                chk("commit_tag", 64'(bus.commit_tag), 64'(e_commit_tag));
            end
            chk("clear", 64'(bus.clear), 64'(e_clear));
            if (e_clear) chk("pc_redirect", 64'(bus.pc_redirect), 64'(e_pc_redirect));
            qr = 0; qd = 0;
            if (bus.query_tag != 0 && bus.query_tag == bus.tag_from_ex) begin
                qr = 1; qd = bus.data_from_ex;
            end else
                foreach (q[i]) if (q[i].tag == bus.query_tag && q[i].done) begin
                    qr = 1; qd = q[i].val;
                end
            chk("query_ready", 64'(bus.query_ready), 64'(qr));
            if (qr) chk("query_data", 64'(bus.query_data), 64'(qd));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input int d, input bit br, input bit pred, input int pc);
        bus.if_issue_rob = 1; bus.dest_reg = 5'(d); bus.is_branch = br;
        bus.pred_taken = pred; bus.pc_in = 32'(pc);
        tick();
        bus.if_issue_rob = 0;
    endtask

    task automatic wb(input int t, input int d, input bit tk, input int tgt);
        bus.tag_from_ex = 4'(t); bus.data_from_ex = 32'(d);
        bus.taken_from_ex = tk; bus.target_from_ex = 32'(tgt);
        tick();
        bus.tag_from_ex = 0;
    endtask

    initial begin
        bus.rdy = 1; bus.if_issue_rob = 0; bus.dest_reg = 0; bus.is_branch = 0;
        bus.pred_taken = 0; bus.pc_in = 0; bus.query_tag = 0; bus.tag_from_ex = 0;
        bus.data_from_ex = 0; bus.taken_from_ex = 0; bus.target_from_ex = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst free_tag", 64'(bus.free_tag), 64'(1));
        chk("rst if_idle", 64'(bus.if_idle), 64'(1));
        chk("rst commit_en", 64'(bus.commit_en), 64'(0));

        // In-order commit after out-of-order writeback
        alloc(1, 0, 0, 'h100); alloc(2, 0, 0, 'h104); alloc(3, 0, 0, 'h108);
        chk("t2 free_tag", 64'(bus.free_tag), 64'(4));
        wb(2, 'h55, 0, 0);
        chk("t2 tag_renew", 64'(bus.tag_renew), 64'(2));
        chk("t2 data_renew", 64'(bus.data_renew), 64'('h55));
        chk("t2 no commit", 64'(bus.commit_en), 64'(0));
        wb(1, 'h11, 0, 0);
        chk("t2 no commit yet", 64'(bus.commit_en), 64'(0));
        tick();
        chk("t2 commit1 en", 64'(bus.commit_en), 64'(1));
        chk("t2 commit1 tag", 64'(bus.commit_tag), 64'(1));
        chk("t2 commit1 data", 64'(bus.commit_data), 64'('h11));
        tick();
        chk("t2 commit2 tag", 64'(bus.commit_tag), 64'(2));
        chk("t2 commit2 data", 64'(bus.commit_data), 64'('h55));

        // Asynchronous reset in the middle of a commit pulse
        #2 rst = 1;
        #1;
        chk("arst commit_en", 64'(bus.commit_en), 64'(0));
        chk("arst commit_tag", 64'(bus.commit_tag), 64'(0));
        chk("arst commit_data", 64'(bus.commit_data), 64'(0));
        chk("arst data_renew", 64'(bus.data_renew), 64'(0));
        chk("arst free_tag", 64'(bus.free_tag), 64'(1));
        chk("arst if_idle", 64'(bus.if_idle), 64'(1));
        @(posedge clk);
        #1 rst = 0;

        // Fill to capacity, wrap, refuse, then free one slot
        for (int i = 0; i < 15; i++) alloc(i + 1, 0, 0, 'h400 + 4 * i);
        chk("t3 full if_idle", 64'(bus.if_idle), 64'(0));
        chk("t3 wrap free_tag", 64'(bus.free_tag), 64'(1));
        alloc(9, 0, 0, 'h4ff);
        chk("t3 refused", 64'(bus.free_tag), 64'(1));
        wb(1, 'h1000, 0, 0);
        tick();
        chk("t3 commit tag", 64'(bus.commit_tag), 64'(1));
        chk("t3 if_idle", 64'(bus.if_idle), 64'(1));
        alloc(20, 0, 0, 'h500);
        chk("t3 got tag1", 64'(bus.free_tag), 64'(2));
        for (int t = 2; t < 16; t++) wb(t, 'h2000 + t, 0, 0);
        wb(1, 'h3000, 0, 0);
        repeat (3) tick();

        // Mispredicted taken branch with a younger instruction behind it
        alloc(1, 1, 0, 'h200); alloc(5, 0, 0, 'h204);
        wb(2, 'h204, 1, 'h1000);
        chk("t4 tag_renew", 64'(bus.tag_renew), 64'(2));
        alloc(6, 0, 0, 'h208);
        chk("t4 clear", 64'(bus.clear), 64'(1));
        chk("t4 pc_redirect", 64'(bus.pc_redirect), 64'('h1000));
        chk("t4 link data", 64'(bus.commit_data), 64'('h204));
        chk("t4 free_tag", 64'(bus.free_tag), 64'(1));
        wb(3, 'h77, 0, 0);
        chk("t4 no broadcast", 64'(bus.tag_renew), 64'(0));
        chk("t4 clear once", 64'(bus.clear), 64'(0));
        alloc(0, 1, 1, 'h300);
        wb(1, 0, 0, 'h5000);
        tick();
        chk("t4b clear", 64'(bus.clear), 64'(1));
        chk("t4b pc+4", 64'(bus.pc_redirect), 64'('h304));
        chk("t4b commit_en", 64'(bus.commit_en), 64'(0));

        // dest_reg 0 commits silently
        alloc(0, 0, 0, 'h500); alloc(7, 0, 0, 'h504);
        wb(1, 'hAA, 0, 0);
        wb(2, 'hBB, 0, 0);
        chk("t5 silent commit", 64'(bus.commit_en), 64'(0));
        chk("t5 tag_renew", 64'(bus.tag_renew), 64'(2));
        tick();
        chk("t5 commit_en", 64'(bus.commit_en), 64'(1));
        chk("t5 commit_tag", 64'(bus.commit_tag), 64'(2));
        chk("t5 commit_reg", 64'(bus.commit_reg), 64'(7));

        // Stall with an EX result held on the bus
        alloc(8, 0, 0, 'h600); alloc(9, 0, 0, 'h604);
        bus.rdy = 0; bus.tag_from_ex = 4; bus.data_from_ex = 'h44; bus.query_tag = 4;
        bus.if_issue_rob = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6 stall tag_renew", 64'(bus.tag_renew), 64'(0));
            chk("t6 fwd query_ready", 64'(bus.query_ready), 64'(1));
        end
        bus.if_issue_rob = 0; bus.rdy = 1;
        tick();
        chk("t6 tag_renew", 64'(bus.tag_renew), 64'(4));
        chk("t6 data_renew", 64'(bus.data_renew), 64'('h44));
        bus.tag_from_ex = 0;
        #1;
        chk("t6 stored query", 64'(bus.query_data), 64'('h44));
        chk("t6 free_tag", 64'(bus.free_tag), 64'(5));
        bus.query_tag = 3;
        #1;
        chk("t6 not ready", 64'(bus.query_ready), 64'(0));
        bus.query_tag = 0;
        #1;
        chk("t6 tag0 query", 64'(bus.query_ready), 64'(0));
        wb(3, 'h33, 0, 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
